// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg
// Shared definitions for the streaming front end of the network:
//   DATA_WIDTH_DEF - default sample width (network dataWidth)
//   FRAME_LEN_DEF  - default samples per frame (layer-1 weight count)
//   rd_state_t     - read-side FSM states of input_frame_buffer
package nn_stream_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAME_LEN_DEF  = 784;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_STREAM    = 2'd1,
    RD_WAIT_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/frame_ram.sv
// frame_ram
// Simple dual-port sample store holding two frame banks. The bank select is
// the address MSB, so each bank occupies a power-of-two aligned half.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - {bank, sample index} write address
//   wr_data - sample to store
//   rd_en   - read strobe
//   rd_addr - {bank, sample index} read address
//   rd_data - read sample, valid one cycle after rd_en
module frame_ram
  import nn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW:0]           rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/input_frame_buffer.sv
// input_frame_buffer
// Ping-pong frame buffer between the host DMA stream and layer 1. Frames are
// written into one bank while the other is streamed out at one sample per
// cycle; a bank is only released for writing once it has been fully read.
// Ports:
//   clk             - clock
//   rst             - asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready - AXI-Stream sample input
//   m_data/m_valid  - sample stream to layer 1 (no backpressure)
//   net_done        - pulse when the network has finished a frame
//   frames_buffered - number of full banks (0..2)
//   frame_err       - pulse on a framing error (early or missing s_last)
//   busy            - read FSM is not idle
module input_frame_buffer
  import nn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  net_done,
  output logic [1:0]            frames_buffered,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic                  wr_bank;
  logic [AW-1:0]         wr_addr;
  logic                  rd_bank;
  logic [AW-1:0]         rd_addr;
  rd_state_t             state;

  logic                  wr_hs;
  logic                  wr_at_end;
  logic                  wr_complete;
  logic                  wr_abort;
  logic                  rd_en;
  logic                  rd_free;

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // s_ready is forced low while reset is held, independent of the flags.
  assign s_ready     = ~rst & ~full[wr_bank];
  assign wr_hs       = s_valid & s_ready;
  assign wr_at_end   = (wr_addr == LAST_ADDR);
  assign wr_complete = wr_hs & wr_at_end;
  assign wr_abort    = wr_hs & s_last & ~wr_at_end;
  assign rd_en       = (state == RD_STREAM);
  assign rd_free     = rd_en & (rd_addr == LAST_ADDR);

  // A write can only complete into an empty bank and a read can only free a
  // full one, so the two updates never target the same flag.
  always_comb begin
    full_nxt = full;
    if (rd_free)     full_nxt[rd_bank] = 1'b0;
    if (wr_complete) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full            <= 2'b00;
      frames_buffered <= 2'd0;
      frame_err       <= 1'b0;
      wr_bank         <= 1'b0;
      wr_addr         <= '0;
    end else begin
      full            <= full_nxt;
      frames_buffered <= 2'(full_nxt[0]) + 2'(full_nxt[1]);
      frame_err       <= (wr_complete & ~s_last) | wr_abort;
      if (wr_complete) begin
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
      end else if (wr_abort) begin
        // Partial frame is dropped; the same bank is refilled from sample 0.
        wr_addr <= '0;
      end else if (wr_hs) begin
        wr_addr <= wr_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (full[rd_bank]) begin
            state   <= RD_STREAM;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        RD_STREAM: begin
          if (rd_addr == LAST_ADDR) begin
            state   <= RD_WAIT_DONE;
            rd_addr <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        RD_WAIT_DONE: begin
          if (net_done) begin
            state <= RD_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (wr_hs),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (data_p0)
  );

  // ---- p0: RAM read issued, data returns next cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_en;
  end

  // ---- p1: registered output; data holds its last value when idle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= data_p0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = data_p1;

endmodule
